// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//
// Multi-cycle 32-bit restoring divider for the MIPS54 div/divu instructions.
// One quotient bit is produced per RUN cycle; a final FIX cycle applies sign
// correction and loads the result registers. busy stalls the PC/RF clocks
// while an operation is in flight; done pulses for one cycle with q/r valid.
//
// Configuration macro: DIVIDER_SIGNED_EN
//   defined   : sign input honoured, FIX performs sign correction (div)
//   undefined : sign ignored, every operation is unsigned (divu only)
//   Latency is identical in both builds.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request (div | divu decode)
//   sign      in   1 = signed, 0 = unsigned; sampled with start
//   dividend  in   rs value; sampled with start
//   divisor   in   rt value; sampled with start
//   busy      out  operation in progress (RUN or FIX)
//   done      out  one-cycle pulse, q/r valid
//   q         out  quotient (to LO)
//   r         out  remainder (to HI)
//   div_zero  out  last operation had a zero divisor
// -----------------------------------------------------------------------------
module iterative_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dvd_neg_q, dvs_neg_q, zero_q;
    logic [WIDTH-1:0] q_q, r_q;
    logic             dz_q;

    // Operand conditioning at start time.
    logic             signed_op;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             accept;
    logic             last_iter;

`ifdef DIVIDER_SIGNED_EN
    assign signed_op = sign;
`else
    // Signed support compiled out: the sign request is deliberately dropped.
    logic unused_sign;
    assign unused_sign = sign;
    assign signed_op   = 1'b0;
`endif

    assign dvd_neg   = signed_op & dividend[WIDTH-1];
    assign dvs_neg   = signed_op & divisor[WIDTH-1];
    assign dvd_mag   = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag   = dvs_neg ? (~divisor + 1'b1) : divisor;
    assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // One restoring step: shift the dividend MSB into the partial remainder
    // and try to subtract. 33 bits suffice because shifted < 2*divisor.
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] rem_step, quo_step;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    // FIX-stage results. With a zero divisor the loop leaves |dividend| in the
    // remainder, so the usual remainder sign rule restores the original value.
    logic [WIDTH-1:0] q_fix, r_fix;

    assign q_fix = zero_q ? '1 :
                   ((dvd_neg_q ^ dvs_neg_q) ? (~quo_q + 1'b1) : quo_q);
    assign r_fix = dvd_neg_q ? (~rem_q + 1'b1) : rem_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_RUN, S_FIX: busy = 1'b1;
            S_DONE:       done = 1'b1;
            default:      ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            dz_q      <= 1'b0;
        end else if (accept) begin
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            cnt_q     <= '0;
            dvd_neg_q <= dvd_neg;
            dvs_neg_q <= dvs_neg;
            zero_q    <= (divisor == '0);
        end else if (state_q == S_RUN) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (state_q == S_FIX) begin
            q_q  <= q_fix;
            r_q  <= r_fix;
            dz_q <= zero_q;
        end
    end

    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// -----------------------------------------------------------------------------
// tb_iterative_divider
//
// Directed self-checking bench for iterative_divider. Inputs change on the
// falling edge; outputs are sampled on the falling edge. Expected values are
// hand-computed; the signed expectations follow DIVIDER_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    iterative_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Drive a request; caller is positioned at a falling edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sign     = s;
    endtask

    // Wait for done after a launch. Returns at the falling edge of the done
    // cycle. edges counts E0 as 1; busy_cnt counts busy cycles after E0.
    task automatic wait_done(output logic [31:0] oq, output logic [31:0] orr,
                             output logic odz, output int edges, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        oq       = '0;
        orr      = '0;
        odz      = 1'b0;
        busy_cnt = 0;
        @(posedge clk);
        edges = 1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                oq   = q;
                orr  = r;
                odz  = div_zero;
            end else begin
                if (busy) busy_cnt++;
                @(posedge clk);
                edges++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within %0d edges", edges);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (q !== 32'h0)        begin bad++; $display("FAIL reset_q: got %h want 0", q); end
        total++; if (r !== 32'h0)        begin bad++; $display("FAIL reset_r: got %h want 0", r); end
        total++; if (div_zero !== 1'b0)  begin bad++; $display("FAIL reset_dz: got %b want 0", div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [31:0] oq, orr; logic odz; int e, b;
        launch(32'd100, 32'd7, 1'b0);
        wait_done(oq, orr, odz, e, b);
        total++; if (oq !== 32'd14)  begin bad++; $display("FAIL udiv_q: got %h want %h", oq, 32'd14); end
        total++; if (orr !== 32'd2)  begin bad++; $display("FAIL udiv_r: got %h want %h", orr, 32'd2); end
        total++; if (odz !== 1'b0)   begin bad++; $display("FAIL udiv_dz: got %b want 0", odz); end
        total++; if (e != 34)        begin bad++; $display("FAIL udiv_latency: got %0d want 34", e); end
        total++; if (b != 33)        begin bad++; $display("FAIL udiv_busy_cycles: got %0d want 33", b); end
        @(negedge clk);
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL udiv_done_pulse: got %b want 0", done); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL udiv_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_signed();
        logic [31:0] oq, orr, eq, er; logic odz; int e, b;
`ifdef DIVIDER_SIGNED_EN
        eq = 32'hFFFF_FFFD; er = 32'hFFFF_FFFF;
`else
        eq = 32'h7FFF_FFFC; er = 32'h0000_0001;
`endif
        @(negedge clk);
        launch(32'hFFFF_FFF9, 32'h2, 1'b1);
        wait_done(oq, orr, odz, e, b);
        total++; if (oq !== eq)     begin bad++; $display("FAIL sdiv_q: got %h want %h", oq, eq); end
        total++; if (orr !== er)    begin bad++; $display("FAIL sdiv_r: got %h want %h", orr, er); end
        total++; if (e != 34)       begin bad++; $display("FAIL sdiv_latency: got %0d want 34", e); end
    endtask

    task automatic test_div_zero();
        logic [31:0] oq, orr; logic odz; int e, b;
        @(negedge clk);
        launch(32'h1234_5678, 32'h0, 1'b0);
        wait_done(oq, orr, odz, e, b);
        total++; if (oq !== 32'hFFFF_FFFF)  begin bad++; $display("FAIL dz_q: got %h want ffffffff", oq); end
        total++; if (orr !== 32'h1234_5678) begin bad++; $display("FAIL dz_r: got %h want 12345678", orr); end
        total++; if (odz !== 1'b1)          begin bad++; $display("FAIL dz_flag: got %b want 1", odz); end
        total++; if (e != 34)               begin bad++; $display("FAIL dz_latency: got %0d want 34", e); end
        // Negative dividend with sign requested: original value returned either way.
        @(negedge clk);
        launch(32'h8000_0005, 32'h0, 1'b1);
        wait_done(oq, orr, odz, e, b);
        total++; if (oq !== 32'hFFFF_FFFF)  begin bad++; $display("FAIL dz_neg_q: got %h want ffffffff", oq); end
        total++; if (orr !== 32'h8000_0005) begin bad++; $display("FAIL dz_neg_r: got %h want 80000005", orr); end
        total++; if (odz !== 1'b1)          begin bad++; $display("FAIL dz_neg_flag: got %b want 1", odz); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] oq, orr, eq, er; logic odz; int e, b;
`ifdef DIVIDER_SIGNED_EN
        eq = 32'h8000_0000; er = 32'h0;
`else
        eq = 32'h0; er = 32'h8000_0000;
`endif
        @(negedge clk);
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(oq, orr, odz, e, b);
        total++; if (oq !== eq)    begin bad++; $display("FAIL ovf_q: got %h want %h", oq, eq); end
        total++; if (orr !== er)   begin bad++; $display("FAIL ovf_r: got %h want %h", orr, er); end
        total++; if (odz !== 1'b0) begin bad++; $display("FAIL ovf_dz: got %b want 0", odz); end
        // Start during the done cycle: accepted at the next edge.
        launch(32'd9, 32'd3, 1'b0);
        wait_done(oq, orr, odz, e, b);
        total++; if (oq !== 32'd3) begin bad++; $display("FAIL b2b_q: got %h want 3", oq); end
        total++; if (orr !== 32'd0) begin bad++; $display("FAIL b2b_r: got %h want 0", orr); end
        total++; if (e != 34)      begin bad++; $display("FAIL b2b_latency: got %0d want 34", e); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_ignore_start();
        logic [31:0] oq, orr; bit seen; int e, k;
        seen = 1'b0; oq = '0; orr = '0; k = 0;
        @(negedge clk);
        launch(32'd1000, 32'd10, 1'b0);
        @(posedge clk);
        e = 1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (k == 5 || k == 20) launch(32'd5, 32'd1, 1'b1);
            else start = 1'b0;
            if (done) begin
                seen = 1'b1; oq = q; orr = r; start = 1'b0;
            end else begin
                @(posedge clk);
                e++;
            end
        end
        total++; if (!seen)          begin bad++; $display("FAIL ign_timeout: got no done want done"); end
        total++; if (oq !== 32'd100) begin bad++; $display("FAIL ign_q: got %h want %h", oq, 32'd100); end
        total++; if (orr !== 32'd0)  begin bad++; $display("FAIL ign_r: got %h want 0", orr); end
        total++; if (e != 34)        begin bad++; $display("FAIL ign_latency: got %0d want 34", e); end
        @(negedge clk);
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL ign_restart: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] oq, orr; logic odz; int e, b; bit saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        launch(32'hFFFF_FFFF, 32'h10, 1'b0);
        @(posedge clk);
        repeat (10) begin @(negedge clk); start = 1'b0; end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_run_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_run_done: got %b want 0", done); end
        total++; if (q !== 32'h0)   begin bad++; $display("FAIL rst_run_q: got %h want 0", q); end
        total++; if (r !== 32'h0)   begin bad++; $display("FAIL rst_run_r: got %h want 0", r); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total++; if (saw_done) begin bad++; $display("FAIL rst_run_stray_done: got done=1 want 0"); end
        launch(32'hFFFF_FFFF, 32'h10, 1'b0);
        wait_done(oq, orr, odz, e, b);
        total++; if (oq !== 32'h0FFF_FFFF) begin bad++; $display("FAIL post_rst_q: got %h want 0fffffff", oq); end
        total++; if (orr !== 32'hF)        begin bad++; $display("FAIL post_rst_r: got %h want f", orr); end
        total++; if (e != 34)              begin bad++; $display("FAIL post_rst_latency: got %0d want 34", e); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
